// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with return-address stack feeding the ICU
// Optional stack overflow/underflow trap: define PC_SEQ_STACK_TRAP_EN.
module pc_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jmp,
  input  logic                       rtn,
  input  logic                       halt,
  input  logic [ADDR_W-1:0]          jmp_addr,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH-1);

  logic [ADDR_W-1:0] stack_mem [DEPTH];
  logic [IDX_W-1:0]  top;
  logic [IDX_W-1:0]  top_inc;
  logic [IDX_W-1:0]  top_dec;
  logic [IDX_W-1:0]  top_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [CNT_W-1:0]  depth_nxt;
  logic              push;
  logic              frozen;
`ifdef PC_SEQ_STACK_TRAP_EN
  logic              fault;
`endif

  // top is the next free slot; it wraps so a full stack overwrites its oldest entry
  assign pc_inc  = pc + ADDR_W'(1);
  assign top_inc = (top == IDX_LAST) ? '0 : top + IDX_W'(1);
  assign top_dec = (top == '0) ? IDX_LAST : top - IDX_W'(1);
  assign full    = (depth == CNT_MAX);
  assign empty   = (depth == '0);
  assign frozen  = halt | err;

  always_comb begin
    pc_nxt    = pc;
    top_nxt   = top;
    depth_nxt = depth;
    push      = 1'b0;
`ifdef PC_SEQ_STACK_TRAP_EN
    fault     = 1'b0;
`endif
    if (!frozen) begin
      if (rtn) begin
        if (empty) begin
`ifdef PC_SEQ_STACK_TRAP_EN
          fault = 1'b1;
`else
          pc_nxt = '0;
`endif
        end else begin
          pc_nxt    = stack_mem[top_dec];
          top_nxt   = top_dec;
          depth_nxt = depth - CNT_W'(1);
        end
      end else if (jmp) begin
`ifdef PC_SEQ_STACK_TRAP_EN
        if (full) begin
          fault = 1'b1;
        end else begin
          push      = 1'b1;
          pc_nxt    = jmp_addr;
          top_nxt   = top_inc;
          depth_nxt = depth + CNT_W'(1);
        end
`else
        push    = 1'b1;
        pc_nxt  = jmp_addr;
        top_nxt = top_inc;
        if (!full) begin
          depth_nxt = depth + CNT_W'(1);
        end
`endif
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      top   <= '0;
      depth <= '0;
    end else begin
      pc    <= pc_nxt;
      top   <= top_nxt;
      depth <= depth_nxt;
    end
  end

  // Entries are meaningful only while counted in depth, so they carry no reset
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[top] <= pc_inc;
    end
  end

`ifdef PC_SEQ_STACK_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (fault) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
